// File: rtl/key_sched_pkg.sv
// key_sched_pkg
// Shared definitions for the iterative AES key schedule:
//   - key-mode encodings (AES-128/192/256, reserved)
//   - controller state encoding
//   - per-mode NK (key words), Nr (rounds) and W (total schedule words)
//   - NB_WORD word width, round-constant start value, GF(2^8) xtime
package key_sched_pkg;

  localparam int NB_WORD = 32;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    MODE_128  = 2'd0,
    MODE_192  = 2'd1,
    MODE_256  = 2'd2,
    MODE_RSVD = 2'd3
  } key_mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  function automatic logic [3:0] mode_nk(input key_mode_t mode);
    case (mode)
      MODE_192: return 4'd6;
      MODE_256: return 4'd8;
      default:  return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] mode_nr(input key_mode_t mode);
    case (mode)
      MODE_192: return 4'd12;
      MODE_256: return 4'd14;
      default:  return 4'd10;
    endcase
  endfunction

  function automatic logic [5:0] mode_words(input key_mode_t mode);
    case (mode)
      MODE_192: return 6'd52;
      MODE_256: return 6'd60;
      default:  return 6'd44;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x80 -> 0x1B).
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/subbytes_block.sv
// subbytes_block
// Applies the AES S-box to each of N_BYTES bytes.  The S-box is computed
// arithmetically (GF(2^8) inverse followed by the affine transform).
// Ports:
//   i_clock  clock, only used when CREATE_OUTPUT_REG is set
//   i_state  N_BYTES*NB_BYTE input bytes
//   o_state  substituted bytes (combinational, or registered when
//            CREATE_OUTPUT_REG = 1)
module subbytes_block
  import key_sched_pkg::*;
#(
  parameter int N_BYTES           = 4,
  parameter int NB_BYTE           = 8,
  parameter bit CREATE_OUTPUT_REG = 1'b0
) (
  input  logic                       i_clock,
  input  logic [N_BYTES*NB_BYTE-1:0] i_state,
  output logic [N_BYTES*NB_BYTE-1:0] o_state
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 = product of x^(2^i), i = 1..7; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return (x == 8'h00) ? 8'h00 : r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  logic [N_BYTES*NB_BYTE-1:0] sub;

  always_comb begin
    sub = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      sub[b*NB_BYTE +: NB_BYTE] = sbox(i_state[b*NB_BYTE +: NB_BYTE]);
    end
  end

  generate
    if (CREATE_OUTPUT_REG) begin : g_reg
      always_ff @(posedge i_clock) begin
        o_state <= sub;
      end
    end else begin : g_comb
      logic unused_clk;
      assign unused_clk = i_clock;
      assign o_state    = sub;
    end
  endgenerate

endmodule

// File: rtl/key_expansion_seq.sv
// key_expansion_seq
// Iterative AES-128/192/256 key expansion, one 32-bit schedule word per
// cycle through a single shared 4-byte S-box.  The schedule lives in an
// internal 60-word register file and is read one round key at a time.
// Ports:
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_start, i_key_mode   start request (IDLE only), 0=128 1=192 2=256 3=rsvd
//   i_key                 MSB-aligned cipher key, w0 in [255:224]
//   i_rd_round            round-key index; o_round_key one cycle later
//   o_round_key           words 4r..4r+3, w(4r) in [127:96], zero if invalid
//   o_busy, o_done        expansion running / one-cycle completion pulse
//   o_key_ready           stored schedule is valid for the latched mode
//   o_err                 one-cycle pulse on a start with the reserved mode
// Optional build macro KEY_SCHED_FULL_VECTOR_EN adds o_round_key_vector,
// the whole schedule flattened (round r in [128r +: 128]).
module key_expansion_seq
  import key_sched_pkg::*;
#(
  parameter int NB_BYTE         = 8,
  parameter int N_BYTES_STATE   = 16,
  parameter int N_BYTES_KEY_MAX = 32,
  parameter int N_ROUNDS_MAX    = 14
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_start,
  input  logic [1:0]                          i_key_mode,
  input  logic [N_BYTES_KEY_MAX*NB_BYTE-1:0]  i_key,
  input  logic [3:0]                          i_rd_round,
  output logic [N_BYTES_STATE*NB_BYTE-1:0]    o_round_key,
`ifdef KEY_SCHED_FULL_VECTOR_EN
  output logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS_MAX+1)-1:0] o_round_key_vector,
`endif
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_key_ready,
  output logic                                o_err
);

  localparam int KEY_W   = N_BYTES_KEY_MAX * NB_BYTE;
  localparam int RK_W    = N_BYTES_STATE * NB_BYTE;
  localparam int N_WORDS = N_BYTES_STATE / 4 * (N_ROUNDS_MAX + 1);

  logic [NB_WORD-1:0] rf [N_WORDS];
  logic [NB_WORD-1:0] key_w [8];

  state_t     state, state_nxt;
  key_mode_t  mode_in;
  logic [3:0] nk_in;
  logic [3:0] nk_q;
  logic [3:0] nr_q;
  logic [5:0] wtot_q;
  logic [5:0] cnt;
  logic [2:0] phase;      // cnt modulo NK, kept incrementally
  logic [7:0] rcon;

  logic start_ok, start_bad, last_wr, busy;

  logic [NB_WORD-1:0] last_word_p0;
  logic [NB_WORD-1:0] sb_in, sb_out, mix, prev_word, new_word;
  logic [5:0]         rd_base;
  logic               rd_ok;

  assign mode_in = key_mode_t'(i_key_mode);
  assign nk_in   = mode_nk(mode_in);

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      key_w[k] = i_key[KEY_W-1-NB_WORD*k -: NB_WORD];
    end
  end

  // ---- FSM: state register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // ---- FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_ok) state_nxt = ST_EXPAND;
      ST_EXPAND: if (last_wr)  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // ---- FSM: output / control decode
  always_comb begin
    start_ok  = (state == ST_IDLE) && i_start && (mode_in != MODE_RSVD);
    start_bad = (state == ST_IDLE) && i_start && (mode_in == MODE_RSVD);
    busy      = (state == ST_EXPAND);
    last_wr   = busy && (cnt == wtot_q - 6'd1);
  end

  assign o_busy = busy;

  // ---- control registers: pulses, ready flag, counters, round constant
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_key_ready <= 1'b0;
      nk_q        <= 4'd4;
      nr_q        <= 4'd0;
      wtot_q      <= 6'd44;
      cnt         <= 6'd0;
      phase       <= 3'd0;
      rcon        <= RCON_INIT;
    end else begin
      o_done <= last_wr;
      o_err  <= start_bad;
      if (start_ok)     o_key_ready <= 1'b0;
      else if (last_wr) o_key_ready <= 1'b1;

      if (start_ok) begin
        nk_q   <= nk_in;
        nr_q   <= mode_nr(mode_in);
        wtot_q <= mode_words(mode_in);
        cnt    <= {2'b00, nk_in};
        phase  <= 3'd0;
        rcon   <= RCON_INIT;
      end else if (busy) begin
        cnt <= cnt + 6'd1;
        if ({1'b0, phase} == nk_q - 4'd1) phase <= 3'd0;
        else                              phase <= phase + 3'd1;
        if (phase == 3'd0) rcon <= xtime(rcon);
      end
    end
  end

  // ---- stage 0: word mix (one S-box pass, rotation only on i%NK == 0)
  assign sb_in = (phase == 3'd0) ? {last_word_p0[23:0], last_word_p0[31:24]}
                                 : last_word_p0;

  subbytes_block #(
    .N_BYTES           (4),
    .NB_BYTE           (NB_BYTE),
    .CREATE_OUTPUT_REG (1'b0)
  ) u_subword (
    .i_clock (i_clock),
    .i_state (sb_in),
    .o_state (sb_out)
  );

  always_comb begin
    prev_word = rf[cnt - {2'b00, nk_q}];
    if (phase == 3'd0)                       mix = sb_out ^ {rcon, 24'h000000};
    else if (nk_q == 4'd8 && phase == 3'd4)  mix = sb_out;
    else                                     mix = last_word_p0;
    new_word = prev_word ^ mix;
  end

  // ---- register file and last-word register (data, not reset)
  always_ff @(posedge i_clock) begin
    if (start_ok) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) < nk_in) rf[k] <= key_w[k];
      end
      last_word_p0 <= key_w[3'(nk_in - 4'd1)];
    end else if (busy) begin
      rf[cnt]      <= new_word;
      last_word_p0 <= new_word;
    end
  end

  // ---- stage 1: registered round-key read
  assign rd_base = {i_rd_round, 2'b00};
  assign rd_ok   = o_key_ready && (i_rd_round <= nr_q);

  always_ff @(posedge i_clock) begin
    if (i_reset)    o_round_key <= '0;
    else if (rd_ok) o_round_key <= {rf[rd_base], rf[rd_base + 6'd1],
                                    rf[rd_base + 6'd2], rf[rd_base + 6'd3]};
    else            o_round_key <= '0;
  end

`ifdef KEY_SCHED_FULL_VECTOR_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_round_key_vector <= '0;
    end else begin
      for (int r = 0; r <= N_ROUNDS_MAX; r++) begin
        if (o_key_ready && (4'(r) <= nr_q))
          o_round_key_vector[RK_W*r +: RK_W] <= {rf[4*r], rf[4*r+1], rf[4*r+2], rf[4*r+3]};
        else
          o_round_key_vector[RK_W*r +: RK_W] <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_key_expansion_seq.sv
// tb_key_expansion_seq
// Self-checking bench for key_expansion_seq: known-answer table, multi-cycle
// corner sequences (reset mid-expansion, ignored restart, reserved mode) and
// randomized keys checked against a table-driven FIPS-197 reference model.
module tb_key_expansion_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key;
  logic [3:0]   rd;
  logic [127:0] round_key;
  logic         busy, done, key_ready, err;
`ifdef KEY_SCHED_FULL_VECTOR_EN
  logic [1919:0] rk_vec;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_expansion_seq dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_key_mode  (mode),
    .i_key       (key),
    .i_rd_round  (rd),
    .o_round_key (round_key),
`ifdef KEY_SCHED_FULL_VECTOR_EN
    .o_round_key_vector (rk_vec),
`endif
    .o_busy      (busy),
    .o_done      (done),
    .o_key_ready (key_ready),
    .o_err       (err)
  );

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] RCON_ALL = 80'h01020408102040801b36;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // ---------------- reference model ----------------
  logic [31:0] ref_w [60];
  int          ref_nr;
  int          ref_nk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX_TAB[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  task automatic model_expand(input int m, input logic [255:0] k);
    logic [31:0] t;
    int total;
    ref_nk = (m == 0) ? 4 : (m == 1) ? 6 : 8;
    ref_nr = ref_nk + 6;
    total  = 4 * (ref_nr + 1);
    for (int i = 0; i < 60; i++) ref_w[i] = 32'h0;
    for (int i = 0; i < ref_nk; i++) ref_w[i] = k[255 - 32*i -: 32];
    for (int i = ref_nk; i < total; i++) begin
      t = ref_w[i-1];
      if (i % ref_nk == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {RCON_ALL[79 - 8*(i/ref_nk - 1) -: 8], 24'h0};
      else if (ref_nk > 6 && i % ref_nk == 4)
        t = sub_word(t);
      ref_w[i] = ref_w[i-ref_nk] ^ t;
    end
  endtask

  function automatic logic [127:0] ref_round(input int r);
    if (r > ref_nr) return 128'h0;
    return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_expand(input logic [1:0] m, input logic [255:0] k, output int lat);
    bit seen;
    mode  = m;
    key   = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 256'(busy), 256'(1));
    check("start_done_low", 256'(done), 256'(0));
    check("start_ready_low", 256'(key_ready), 256'(0));
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      tick();
      lat++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 256'(seen), 256'(1));
    check("done_ready", 256'(key_ready), 256'(1));
    check("done_busy_low", 256'(busy), 256'(0));
  endtask

  task automatic read_round(input int r, output logic [127:0] d);
    rd = 4'(r);
    tick();
    d = round_key;
  endtask

  typedef struct {
    logic [1:0]   m;
    logic [255:0] k;
    int           r;
    int           lat;
    logic [127:0] rk;
  } kat_t;

  kat_t kats [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           lat;
    logic [127:0] d;
    bit           seen;
    int           m;
    logic [255:0] k;

    kats[0] = '{2'd0, K128, 10, 40, R128_10};
    kats[1] = '{2'd0, K128, 0,  40, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    kats[2] = '{2'd0, K128, 11, 40, 128'h0};
    kats[3] = '{2'd1, K192, 12, 46, 128'he98ba06f448c773c8ecc720401002202};
    kats[4] = '{2'd2, K256, 14, 52, 128'hfe4890d1e6188d0b046df344706c631e};

    rst = 1'b1; start = 1'b0; mode = 2'd0; key = '0; rd = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_ready", 256'(key_ready), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_rk", 256'(round_key), 256'(0));

    // Known-answer table
    for (int i = 0; i < 5; i++) begin
      run_expand(kats[i].m, kats[i].k, lat);
      check($sformatf("kat%0d_lat", i), 256'(lat), 256'(kats[i].lat));
      read_round(kats[i].r, d);
      check($sformatf("kat%0d_rk", i), 256'(d), 256'(kats[i].rk));
    end

    // Restart requests during expansion are ignored
    mode = 2'd0; key = K128; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; seen = 1'b0;
    begin
      bit err_seen;
      err_seen = 1'b0;
      while (!seen && lat < 200) begin
        if (lat == 10)      begin start = 1'b1; mode = 2'd2; key = K256; end
        else if (lat == 11) begin start = 1'b1; mode = 2'd3; end
        else                start = 1'b0;
        tick();
        lat++;
        if (err) err_seen = 1'b1;
        if (done) seen = 1'b1;
      end
      start = 1'b0;
      check("mid_start_no_err", 256'(err_seen), 256'(0));
    end
    check("mid_start_done", 256'(seen), 256'(1));
    check("mid_start_lat", 256'(lat), 256'(40));
    read_round(10, d);
    check("mid_start_r10", 256'(d), 256'(R128_10));

    // Reserved mode in IDLE: single err pulse, schedule kept
    mode = 2'd3; key = K256; start = 1'b1;
    tick();
    start = 1'b0;
    check("rsvd_err", 256'(err), 256'(1));
    check("rsvd_busy", 256'(busy), 256'(0));
    check("rsvd_ready", 256'(key_ready), 256'(1));
    tick();
    check("rsvd_err_low", 256'(err), 256'(0));
    check("rsvd_busy_low", 256'(busy), 256'(0));
    read_round(10, d);
    check("rsvd_r10_kept", 256'(d), 256'(R128_10));

`ifdef KEY_SCHED_FULL_VECTOR_EN
    tick();
    check("vec_r0", 256'(rk_vec[127:0]), 256'(K128[255:128]));
    check("vec_r10", 256'(rk_vec[1279:1152]), 256'(R128_10));
    check("vec_hi_a", rk_vec[1919:1664], 256'h0);
    check("vec_hi_b", 256'(rk_vec[1663:1408]), 256'h0);
`endif

    // Reset during AES-256 expansion
    mode = 2'd2; key = K256; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 19; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("mid_rst_busy_before", 256'(busy), 256'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if (done) seen = 1'b1;
    check("mid_rst_busy", 256'(busy), 256'(0));
    check("mid_rst_ready", 256'(key_ready), 256'(0));
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("mid_rst_no_done", 256'(seen), 256'(0));
    check("mid_rst_idle", 256'(busy), 256'(0));
    read_round(0, d);
    check("mid_rst_rk_zero", 256'(d), 256'(0));
    run_expand(2'd0, K128, lat);
    check("post_rst_lat", 256'(lat), 256'(40));
    read_round(10, d);
    check("post_rst_r10", 256'(d), 256'(R128_10));

    // Randomized keys and modes against the reference model
    for (int it = 0; it < 8; it++) begin
      m = int'($urandom_range(0, 2));
      for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
      model_expand(m, k);
      run_expand(2'(m), k, lat);
      check($sformatf("rnd%0d_lat", it), 256'(lat), 256'(4*(ref_nr+1) - ref_nk));
      for (int r = 0; r < 16; r++) begin
        read_round(r, d);
        check($sformatf("rnd%0d_m%0d_r%0d", it, m, r), 256'(d), 256'(ref_round(r)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_expansion_seq.md
# key_expansion_seq

Iterative, mode-selectable AES key expansion engine: produces the full round-key schedule for AES-128/192/256 one 32-bit word per cycle, using a single shared 4-byte S-box. Schedule is held in an internal register file and read one round key at a time. It sits ahead of the AES round pipeline and GCTR/GHASH key paths, where the combinational full-unrolled scheduler is too large or a runtime key-length choice is needed.

## Interface
- NB_BYTE, 8, bits per byte; any other value is a bad configuration.
- N_BYTES_STATE, 16, bytes per round key.
- N_BYTES_KEY_MAX, 32, widest supported key (AES-256).
- N_ROUNDS_MAX, 14, rounds for widest key; storage = N_BYTES_STATE/4*(N_ROUNDS_MAX+1) = 60 words.
- i_clock  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  start-expansion request, sampled in IDLE only.
- i_key_mode  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved.
- i_key  in  N_BYTES_KEY_MAX*NB_BYTE  cipher key, MSB-aligned: w0 in [255:224]; AES-128 uses [255:128], AES-192 uses [255:64].
- i_rd_round  in  4  round-key index to read.
- o_round_key  out  N_BYTES_STATE*NB_BYTE  round key i_rd_round; w(4r) in [127:96].
- o_busy  out  1  expansion in progress.
- o_done  out  1  one-cycle pulse, schedule complete.
- o_key_ready  out  1  level, stored schedule is valid for the current mode.
- o_err  out  1  one-cycle pulse, start with reserved mode.

## Operation
- FSM states: IDLE, EXPAND. Reset -> IDLE; all outputs 0; register file contents undefined, o_key_ready 0.
- IDLE & i_start & mode!=3: latch mode, NK (4/6/8), total words W (44/52/60); write w0..w(NK-1) from i_key; last-word register <= w(NK-1); word counter <= NK; rcon <= 0x01; o_key_ready <= 0; -> EXPAND.
- IDLE & i_start & mode==3: o_err pulse, state and stored schedule unchanged.
- EXPAND, each cycle, i = counter, t = last-word register:
  - i%NK==0: t' = SubWord(RotWord(t)) ^ {rcon,24'h0}; rcon <= xtime(rcon) (0x80 -> 0x1B).
  - NK==8 & i%NK==4: t' = SubWord(t).
  - else t' = t.
  - w(i) = w(i-NK) ^ t'; written to file and last-word register; counter++.
- Written word i == W-1: -> IDLE, o_done pulse, o_key_ready <= 1, o_busy <= 0.
- i_start during EXPAND: ignored (no queueing, no o_err).
- Reset mid-expansion: immediate return to IDLE, no o_done, o_key_ready 0.
- Read: o_round_key <= words 4r..4r+3, registered. r > Nr of latched mode, or o_key_ready 0: output zero.
- Single SubWord instance shared by both mix cases (never needed in the same cycle).

## Timing
- Start edge E0; word NK written at E1; word W-1 at EM, M = W-NK: 40 / 46 / 52 for 128/192/256.
- o_done and o_key_ready rise at EM; o_done low at EM+1; o_busy high from E0 to EM.
- Back-to-back: i_start sampled in cycle after o_done begins the next expansion; minimum start-to-start M+1 cycles.
- Read latency 1 cycle, fully pipelined, address may change every cycle.
- S-box path purely combinational (subbytes_block with CREATE_OUTPUT_REG 0); critical path = file mux + S-box + 2 XOR.

## Configuration
- KEY_SCHED_FULL_VECTOR_EN defined: adds output o_round_key_vector, N_BYTES_STATE*NB_BYTE*(N_ROUNDS_MAX+1) bits, registered, round 0 in [127:0], round r in [128r+:128], w(4r) in top 32 bits of each slice; unused rounds of shorter modes zero; valid while o_key_ready. Drop-in for consumers of the flat round-key vector.
- Undefined: port absent, only the read port exists.

## Structure
- Shared package key_sched_pkg: mode encodings, NK/Nr/W per mode, NB_WORD=32, rcon reset value, xtime function.
- Sub-module: existing subbytes_block, N_BYTES=4, one instance. Register file and FSM inline.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> o_done 40 cycles after start; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; round 11 read -> 0.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> o_done after 46 cycles; round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> o_done after 52 cycles; round 14 = fe4890d1e6188d0b046df344706c631e.
- Reset asserted at cycle 20 of AES-256 expansion -> no o_done, o_key_ready 0, o_busy 0 next cycle; fresh AES-128 start then completes correctly.
- i_start pulsed mid-expansion and with mode 3 in IDLE -> former ignored, latter single o_err pulse, prior schedule and o_key_ready retained.
- With KEY_SCHED_FULL_VECTOR_EN, AES-128 vector -> [127:0] = key, [1279:1152] = round 10 above, bits above 1407 zero.
